// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Single-outstanding instruction fetch unit. Issues one memory
//               read per PC, registers the returned word for decode, holds it
//               under stall, redirects on flush and halts on a misaligned
//               target or an unresponsive memory.
// Ports       : clk, reset_n        - clock / async active-low reset
//               input_to_ifu        - next PC from the PC-select mux
//               stall, flush        - pipeline hold / redirect controls
//               imem_req/addr       - memory read request and address
//               imem_ready/rdata    - same-cycle memory response
//               pc, next_address    - current fetch PC and pc + 4
//               instr, instr_valid  - registered instruction for decode
//               misaligned, timeout - sticky fault flags (cleared by reset)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] input_to_ifu,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] next_address,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misaligned,
    output logic        timeout
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_req   = 2'd1;
    localparam logic [1:0]  c_st_valid = 2'd2;
    localparam logic [1:0]  c_st_halt  = 2'd3;

    localparam logic [31:0] c_nop        = 32'h0000_0013;
    // Compare against TIMEOUT-1 so the fault fires on the TIMEOUT-th
    // unanswered cycle rather than one cycle later.
    localparam logic [7:0]  c_timeout_m1 = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_misaligned;
    logic        r_timeout;
    logic [7:0]  r_wait_cnt;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic        w_instr_valid_nxt;
    logic        w_misaligned_nxt;
    logic        w_timeout_nxt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        w_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_st_idle;
            r_pc          <= RESET_PC;
            r_instr       <= c_nop;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
            r_timeout     <= 1'b0;
            r_wait_cnt    <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_misaligned  <= w_misaligned_nxt;
            r_timeout     <= w_timeout_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_misaligned_nxt  = r_misaligned;
        w_timeout_nxt     = r_timeout;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_load            = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_state_nxt = c_st_req;
            end
            c_st_req: begin
                // Flush wins over a same-cycle response: the word is dropped.
                if (flush) begin
                    w_load = 1'b1;
                end else if (imem_ready) begin
                    w_instr_nxt       = imem_rdata;
                    w_instr_valid_nxt = 1'b1;
                    w_wait_cnt_nxt    = 8'd0;
                    w_state_nxt       = c_st_valid;
                end else if (r_wait_cnt == c_timeout_m1) begin
                    w_timeout_nxt  = 1'b1;
                    w_wait_cnt_nxt = 8'd0;
                    w_state_nxt    = c_st_halt;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            c_st_valid: begin
                if (flush || !stall) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                // Halt: only reset leaves this state; stall/flush ignored.
            end
        endcase

        // Common PC-load path for both advance and flush redirects.
        if (w_load) begin
            w_wait_cnt_nxt    = 8'd0;
            w_instr_valid_nxt = 1'b0;
            if (input_to_ifu[1:0] != 2'b00) begin
                w_misaligned_nxt = 1'b1;
                w_state_nxt      = c_st_halt;
            end else begin
                w_pc_nxt    = input_to_ifu;
                w_state_nxt = c_st_req;
            end
        end
    end

    assign imem_req     = (r_state == c_st_req);
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign next_address = r_pc + 32'd4;
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign misaligned   = r_misaligned;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. Directed scenarios
//               followed by randomized traffic compared against a
//               transaction-level model of the fetch behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] input_to_ifu;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] next_address;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misaligned;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    // Model: started / fetching / halted describe where the fetch flow is.
    bit          m_started, m_fetching, m_halted, m_valid, m_mis, m_to;
    logic [31:0] m_pc, m_instr;
    int          m_waited;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .input_to_ifu (input_to_ifu),
        .stall        (stall),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .next_address (next_address),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .misaligned   (misaligned),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_started = 0; m_fetching = 0; m_halted = 0;
        m_valid = 0; m_mis = 0; m_to = 0;
        m_pc = 32'h0; m_instr = 32'h0000_0013; m_waited = 0;
    endfunction

    function automatic void model_redirect(logic [31:0] a);
        m_waited = 0;
        m_valid  = 0;
        if (a % 4 != 0) begin
            m_mis = 1; m_halted = 1; m_fetching = 0;
        end else begin
            m_pc = a; m_fetching = 1;
        end
    endfunction

    function automatic void model_edge();
        if (m_halted) return;
        if (!m_started) begin
            m_started = 1; m_fetching = 1;
            return;
        end
        if (m_fetching) begin
            if (flush) model_redirect(input_to_ifu);
            else if (imem_ready) begin
                m_instr = imem_rdata; m_valid = 1; m_fetching = 0; m_waited = 0;
            end else begin
                m_waited++;
                if (m_waited >= TO) begin
                    m_to = 1; m_halted = 1; m_fetching = 0;
                end
            end
        end else if (flush || !stall) begin
            model_redirect(input_to_ifu);
        end
    endfunction

    // One clock: model follows the DUT edge; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; stall = 1'b0; flush = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678; input_to_ifu = 32'h40;
        apply_reset();
        repeat (4) tick();
        // Assert reset away from any clock edge; outputs must clear at once.
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        total++; if (instr !== 32'h13) begin bad++; $display("FAIL reset_instr: got %h want %h", instr, 32'h13); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (misaligned !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL reset_flags: got %b%b want 00", misaligned, timeout); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        imem_ready = 1'b1; imem_rdata = 32'h0000_0093; stall = 1'b1; flush = 1'b0;
        input_to_ifu = 32'h4;
        apply_reset();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req: got %b want 0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        tick();
        total++; if (instr !== 32'h93 || instr_valid !== 1'b1) begin bad++; $display("FAIL first_instr: got %h/%b want 00000093/1", instr, instr_valid); end
        total++; if (next_address !== 32'h4) begin bad++; $display("FAIL first_next: got %h want 4", next_address); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL first_req_drop: got %b want 0", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] addrs[$];
        int          when[$];
        imem_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            input_to_ifu = m_pc + 32'd4;
            imem_rdata   = $urandom;
            tick();
            if (imem_req) begin addrs.push_back(imem_addr); when.push_back(i); end
        end
        total++; if (addrs.size() != 4) begin bad++; $display("FAIL seq_count: got %0d want 4", addrs.size()); end
        for (int k = 0; k < addrs.size() && k < 4; k++) begin
            total++;
            if (addrs[k] !== 32'(k * 4) || when[k] != 2 * k + 1)
                begin bad++; $display("FAIL seq_addr%0d: got %h@%0d want %h@%0d", k, addrs[k], when[k], k * 4, 2 * k + 1); end
        end
    endtask

    task automatic test_stall();
        // Continues from the VALID state left by test_sequential.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            input_to_ifu = 32'h80;
            tick();
            total++;
            if (pc !== m_pc || instr !== m_instr || instr_valid !== 1'b1 || imem_req !== 1'b0)
                begin bad++; $display("FAIL stall%0d: got pc=%h i=%h v=%b r=%b want pc=%h i=%h v=1 r=0", i, pc, instr, instr_valid, imem_req, m_pc, m_instr); end
        end
        total++; if (pc !== 32'hC) begin bad++; $display("FAIL stall_pc: got %h want c", pc); end
    endtask

    task automatic test_flush_drop();
        logic [31:0] held;
        stall = 1'b0; imem_ready = 1'b0; input_to_ifu = 32'h20;
        tick();
        held = m_instr;
        flush = 1'b1; input_to_ifu = 32'h100; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0;
        total++; if (instr_valid !== 1'b0 || instr !== held) begin bad++; $display("FAIL flush_drop: got %h/%b want %h/0", instr, instr_valid, held); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL flush_addr: got %b/%h want 1/00000100", imem_req, imem_addr); end
    endtask

    task automatic test_misaligned();
        imem_ready = 1'b1; imem_rdata = 32'h0000_0093; stall = 1'b1; flush = 1'b0;
        apply_reset();
        tick(); tick();
        stall = 1'b0; input_to_ifu = 32'h102;
        tick();
        total++; if (misaligned !== 1'b1 || pc !== 32'h0) begin bad++; $display("FAIL mis_flag: got mis=%b pc=%h want 1/0", misaligned, pc); end
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL mis_halt: got req=%b v=%b want 0/0", imem_req, instr_valid); end
        flush = 1'b1; input_to_ifu = 32'h200;
        repeat (3) tick();
        flush = 1'b0;
        total++; if (pc !== 32'h0 || imem_req !== 1'b0 || misaligned !== 1'b1) begin bad++; $display("FAIL mis_stuck: got pc=%h r=%b m=%b want 0/0/1", pc, imem_req, misaligned); end
        apply_reset();
        total++; if (pc !== 32'h0 || misaligned !== 1'b0) begin bad++; $display("FAIL mis_reset: got pc=%h m=%b want 0/0", pc, misaligned); end
    endtask

    task automatic test_timeout();
        imem_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        apply_reset();
        tick();
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO - 1) begin
                total++; if (timeout !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL to_early: got to=%b r=%b want 0/1", timeout, imem_req); end
            end
        end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", timeout); end
        imem_ready = 1'b1;
        repeat (2) tick();
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL to_halt: got r=%b v=%b want 0/0", imem_req, instr_valid); end
    endtask

    task automatic test_wrap();
        imem_ready = 1'b1; stall = 1'b1; flush = 1'b0;
        apply_reset();
        tick(); tick();
        stall = 1'b0; input_to_ifu = 32'hFFFF_FFFC;
        tick();
        total++; if (pc !== 32'hFFFF_FFFC || next_address !== 32'h0 || misaligned !== 1'b0)
            begin bad++; $display("FAIL wrap: got pc=%h next=%h m=%b want fffffffc/0/0", pc, next_address, misaligned); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            int sel;
            imem_ready = ($urandom_range(0, 9) < 7);
            imem_rdata = $urandom;
            stall      = ($urandom_range(0, 9) < 3);
            flush      = ($urandom_range(0, 9) == 0);
            sel        = $urandom_range(0, 99);
            if (sel < 80)      input_to_ifu = m_pc + 32'd4;
            else if (sel < 95) input_to_ifu = $urandom & 32'hFFFF_FFFC;
            else               input_to_ifu = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            tick();
            total++;
            if (pc !== m_pc || next_address !== m_pc + 32'd4 || instr !== m_instr || instr_valid !== m_valid)
                begin bad++; $display("FAIL rnd_data@%0d: got pc=%h n=%h i=%h v=%b want pc=%h i=%h v=%b", i, pc, next_address, instr, instr_valid, m_pc, m_instr, m_valid); end
            total++;
            if (imem_req !== m_fetching || (m_fetching && imem_addr !== m_pc) || misaligned !== m_mis || timeout !== m_to)
                begin bad++; $display("FAIL rnd_ctrl@%0d: got r=%b a=%h m=%b t=%b want r=%b a=%h m=%b t=%b", i, imem_req, imem_addr, misaligned, timeout, m_fetching, m_pc, m_mis, m_to); end
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
                apply_reset();
        end
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        imem_rdata = 32'h0; input_to_ifu = 32'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_sequential();
        test_stall();
        test_flush_drop();
        test_misaligned();
        test_timeout();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
